// File: rtl/fog_lut_streamer.sv
// Fog LUT streamer: captures one LUT frame from a load stream into local
// RAM and replays it as an AXI-Stream frame toward the fog interpolator.
module fog_lut_streamer #(
    parameter int LUT_ENTRIES = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int FRAME_WORDS = 2 + 2 * LUT_ENTRIES
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  start,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  busy,
    output logic                  done,
    output logic                  lut_valid,
    output logic                  frame_error
);
    localparam int CW = $clog2(FRAME_WORDS + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_WORDS - 1);
    localparam logic [CW-1:0] OVF_IDX  = CW'(FRAME_WORDS);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;

    logic [DATA_WIDTH-1:0] mem [FRAME_WORDS];

    logic [1:0]            state_q, state_d;
    logic [CW-1:0]         wr_cnt_q, wr_cnt_d;
    logic [CW-1:0]         rd_cnt_q, rd_cnt_d;
    logic                  lut_valid_q, lut_valid_d;
    logic                  frame_error_q, frame_error_d;
    logic                  tready_q, done_q;
    logic                  o_vld_q, o_vld_d, o_last_q, o_last_d;
    logic                  k_vld_q, k_vld_d, k_last_q, k_last_d;
    logic [DATA_WIDTH-1:0] o_q, o_d, k_q, k_d;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  load_hs, pop, rd_en, rd_last, start_ok;

    assign busy          = (state_q != S_IDLE);
    assign s_axis_tready = tready_q;
    assign load_hs       = s_axis_tvalid && tready_q;
    assign lut_valid     = lut_valid_q;
    assign frame_error   = frame_error_q;
    assign done          = done_q;
    assign m_axis_tvalid = o_vld_q;
    assign m_axis_tdata  = o_q;
    assign m_axis_tlast  = o_vld_q && o_last_q;

    // Words past the frame length park the counter at OVF_IDX until tlast.
    always_comb begin
        wr_cnt_d      = wr_cnt_q;
        lut_valid_d   = lut_valid_q;
        frame_error_d = frame_error_q;
        if (load_hs) begin
            lut_valid_d = 1'b0;
            if (s_axis_tlast) begin
                wr_cnt_d      = '0;
                lut_valid_d   = (wr_cnt_q == LAST_IDX);
                frame_error_d = (wr_cnt_q != LAST_IDX);
            end else if (wr_cnt_q != OVF_IDX) begin
                wr_cnt_d = wr_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (load_hs && wr_cnt_q != OVF_IDX) begin
            mem[wr_cnt_q] <= s_axis_tdata;
        end
    end

    // A load word that invalidates the table in the same cycle drops start.
    assign start_ok = start && !busy && lut_valid_q && lut_valid_d;
    assign pop      = o_vld_q && m_axis_tready;
    assign rdata    = mem[rd_cnt_q];
    assign rd_last  = (rd_cnt_q == LAST_IDX);

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_FETCH;
            end
            S_FETCH: begin
                rd_en   = 1'b1;
                state_d = S_SEND;
            end
            S_SEND: begin
                rd_en = (rd_cnt_q != OVF_IDX) && (!k_vld_q || pop);
                if (pop && o_last_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_cnt_d = rd_cnt_q;
        if (start_ok)   rd_cnt_d = '0;
        else if (rd_en) rd_cnt_d = rd_cnt_q + CW'(1);
    end

    // Output slot o drives the bus; skid slot k absorbs a read under stall.
    always_comb begin
        o_vld_d  = o_vld_q;
        o_last_d = o_last_q;
        o_d      = o_q;
        k_vld_d  = k_vld_q;
        k_last_d = k_last_q;
        k_d      = k_q;
        if (pop) begin
            o_vld_d  = k_vld_q;
            o_last_d = k_last_q;
            o_d      = k_q;
            k_vld_d  = 1'b0;
        end
        if (rd_en) begin
            if (pop ? !k_vld_q : !o_vld_q) begin
                o_vld_d  = 1'b1;
                o_last_d = rd_last;
                o_d      = rdata;
            end else begin
                k_vld_d  = 1'b1;
                k_last_d = rd_last;
                k_d      = rdata;
            end
        end
    end

    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            wr_cnt_q      <= '0;
            rd_cnt_q      <= '0;
            lut_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
            tready_q      <= 1'b0;
            done_q        <= 1'b0;
            o_vld_q       <= 1'b0;
            o_last_q      <= 1'b0;
            o_q           <= '0;
            k_vld_q       <= 1'b0;
            k_last_q      <= 1'b0;
            k_q           <= '0;
        end else begin
            state_q       <= state_d;
            wr_cnt_q      <= wr_cnt_d;
            rd_cnt_q      <= rd_cnt_d;
            lut_valid_q   <= lut_valid_d;
            frame_error_q <= frame_error_d;
            tready_q      <= (state_d == S_IDLE);
            done_q        <= pop && o_last_q;
            o_vld_q       <= o_vld_d;
            o_last_q      <= o_last_d;
            o_q           <= o_d;
            k_vld_q       <= k_vld_d;
            k_last_q      <= k_last_d;
            k_q           <= k_d;
        end
    end

endmodule

// File: tb/tb_fog_lut_streamer.sv
// Bench for fog_lut_streamer: frame-level reference model plus a per-cycle
// stream monitor, with randomized data and downstream backpressure.
module tb_fog_lut_streamer;
    localparam int FW = 66;

    logic        aclk = 1'b0;
    logic        resetn = 1'b0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic        s_axis_tlast = 1'b0;
    logic [31:0] s_axis_tdata = '0;
    logic        start = 1'b0;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic [31:0] m_axis_tdata;
    logic        busy, done, lut_valid, frame_error;

    fog_lut_streamer dut (
        .aclk          (aclk),
        .resetn        (resetn),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .start         (start),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .busy          (busy),
        .done          (done),
        .lut_valid     (lut_valid),
        .frame_error   (frame_error)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, got, exp, cyc);
        end
    endtask

    // Reference model: frame-level view of the load stream.
    logic [31:0] frame_q[$];
    logic [31:0] pend[$];
    bit          m_valid = 1'b0;
    bit          m_err = 1'b0;

    function automatic void model_accept(input logic [31:0] d,
                                         input logic last);
        pend.push_back(d);
        m_valid = 1'b0;
        if (last) begin
            if (pend.size() == FW) begin
                frame_q = pend;
                m_valid = 1'b1;
                m_err   = 1'b0;
            end else begin
                m_err = 1'b1;
            end
            pend.delete();
        end
    endfunction

    // Expected replay words and monitor bookkeeping.
    logic [31:0] exp_q[$];
    int          exp_pos = 0;
    int          hs_total = 0;
    int          last_hs_cyc = -1;
    int          first_v_cyc = 0;
    logic [31:0] last_tdata = '0;
    bit          prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    always @(negedge aclk) begin
        if (!resetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata},
                    {1'b1, prev_last, prev_data});
            if (m_axis_tvalid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tvalid", m_axis_tvalid, 0);
                end else begin
                    chk("tdata", m_axis_tdata, exp_q[0]);
                    chk("tlast", m_axis_tlast, exp_pos == FW - 1);
                    if (m_axis_tready) begin
                        void'(exp_q.pop_front());
                        hs_total++;
                        if (exp_pos == FW - 1) begin
                            last_hs_cyc = cyc;
                            last_tdata  = m_axis_tdata;
                            exp_pos     = 0;
                        end else begin
                            exp_pos++;
                        end
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            chk("lut_valid", lut_valid, m_valid);
            chk("frame_error", frame_error, m_err);
        end
    end

    // Downstream ready: 0 = always, 1 = pattern 1,0,0,1, 2 = random.
    int mode = 0;
    initial begin
        int ph;
        bit pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        ph = 0;
        forever begin
            @(posedge aclk);
            #1;
            case (mode)
                1: begin
                    m_axis_tready = pat[ph % 4];
                    ph++;
                end
                2: m_axis_tready = 1'($urandom_range(0, 1));
                default: m_axis_tready = 1'b1;
            endcase
        end
    end

    task automatic load(input int n, input int last_idx,
                        input logic [31:0] base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = rnd ? $urandom : base + 32'(i);
            s_axis_tlast  = (i == last_idx);
            @(negedge aclk);
            chk("s_tready", s_axis_tready, 1);
            @(posedge aclk);
            model_accept(s_axis_tdata, s_axis_tlast);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic launch(input bit accept);
        if (accept)
            foreach (frame_q[i]) exp_q.push_back(frame_q[i]);
        start = 1'b1;
        @(negedge aclk);
        chk("tvalid_start_cyc", m_axis_tvalid, 0);
        @(posedge aclk);
        #1;
        start = 1'b0;
        @(negedge aclk);
        chk("busy_fetch", busy, accept);
        chk("tvalid_fetch", m_axis_tvalid, 0);
        @(negedge aclk);
        chk("tvalid_start_p2", m_axis_tvalid, accept);
        first_v_cyc = cyc;
        @(posedge aclk);
        #1;
    endtask

    task automatic finish_replay(input bit full_tp);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge aclk);
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", got, 1);
        if (got) begin
            chk("done_after_last", cyc, last_hs_cyc + 1);
            chk("frame_drained", exp_q.size(), 0);
            if (full_tp)
                chk("full_throughput", last_hs_cyc - first_v_cyc, FW - 1);
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            chk("idle_busy", busy, 0);
        end
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int hs0;

        repeat (3) @(posedge aclk);
        #1;
        chk("rst_m_tvalid", m_axis_tvalid, 0);
        chk("rst_s_tready", s_axis_tready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_lut_valid", lut_valid, 0);
        chk("rst_frame_error", frame_error, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        resetn = 1'b1;
        repeat (2) @(posedge aclk);
        #1;

        // 1: counting frame, full throughput
        mode = 0;
        load(FW, FW - 1, 32'd0, 1'b0);
        @(negedge aclk);
        chk("t1_lut_valid", lut_valid, 1);
        chk("t1_frame_error", frame_error, 0);
        @(posedge aclk);
        #1;
        hs0 = hs_total;
        launch(1'b1);
        finish_replay(1'b1);
        chk("t1_handshakes", hs_total - hs0, 66);
        chk("t1_last_word", last_tdata, 32'd65);

        // 2: backpressure 1,0,0,1
        mode = 1;
        hs0 = hs_total;
        launch(1'b1);
        finish_replay(1'b0);
        chk("t2_handshakes", hs_total - hs0, 66);

        // 3: short frame
        mode = 0;
        load(10, 9, 32'h1000, 1'b0);
        @(negedge aclk);
        chk("t3_lut_valid", lut_valid, 0);
        chk("t3_frame_error", frame_error, 1);
        @(posedge aclk);
        #1;
        launch(1'b0);
        idle_check(4);

        // 4: long frame, then good random frame, random ready
        load(70, 69, 32'h2000, 1'b0);
        @(negedge aclk);
        chk("t4_long_error", frame_error, 1);
        chk("t4_long_valid", lut_valid, 0);
        @(posedge aclk);
        #1;
        load(FW, FW - 1, 32'd0, 1'b1);
        @(negedge aclk);
        chk("t4_good_error", frame_error, 0);
        chk("t4_good_valid", lut_valid, 1);
        @(posedge aclk);
        #1;
        mode = 2;
        launch(1'b1);
        finish_replay(1'b0);

        // 5: start and load during busy, then back-to-back replay
        mode = 1;
        launch(1'b1);
        start         = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = 32'hDEADBEEF;
        s_axis_tlast  = 1'b1;
        @(negedge aclk);
        chk("t5_s_tready_busy", s_axis_tready, 0);
        chk("t5_busy", busy, 1);
        @(posedge aclk);
        #1;
        start         = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        finish_replay(1'b0);
        mode = 0;
        launch(1'b1);
        finish_replay(1'b1);

        // 6: reset in the middle of a replay
        mode = 0;
        base = hs_total;
        launch(1'b1);
        for (int i = 0; i < 500; i++) begin
            @(posedge aclk);
            if (hs_total - base >= 20) break;
        end
        chk("t6_reached_20", hs_total - base >= 20, 1);
        #3;
        resetn = 1'b0;
        #1;
        chk("t6_tvalid_async", m_axis_tvalid, 0);
        chk("t6_tlast_async", m_axis_tlast, 0);
        chk("t6_busy_async", busy, 0);
        chk("t6_lut_valid_async", lut_valid, 0);
        exp_q.delete();
        exp_pos = 0;
        pend.delete();
        m_valid = 1'b0;
        m_err   = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        resetn = 1'b1;
        @(posedge aclk);
        #1;
        launch(1'b0);
        idle_check(4);
        load(FW, FW - 1, 32'd0, 1'b1);
        hs0 = hs_total;
        launch(1'b1);
        finish_replay(1'b1);
        chk("t6_reload_handshakes", hs_total - hs0, 66);

        repeat (3) @(posedge aclk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
